// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: per-output-port packet FIFO storing data bytes plus a header flag,
// with a packet-length down-counter and fill status. Define ROUTER_PKT_FIFO_ERR_EN for sticky error flags.
module router_pkt_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int LEN_MSB   = 7,
  parameter int LEN_LSB   = 2,
  parameter int AFULL_LVL = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         soft_reset,
  input  logic                         write_enb,
  input  logic                         read_enb,
  input  logic                         lfd_state,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic                         pkt_active,
  output logic [LEN_MSB-LEN_LSB+1:0]   pkt_remaining,
  output logic                         overflow_err,
  output logic                         underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = LEN_MSB - LEN_LSB + 2;

  logic [WIDTH:0]  mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            lfd_d1;
  logic            wr_acc;
  logic            rd_acc;
  logic [WIDTH:0]  rd_entry;

  // Wrap bit makes the pointer difference an exact occupancy count 0..DEPTH.
  assign fill_level  = wptr - rptr;
  assign full        = (fill_level == PW'(DEPTH));
  assign empty       = (fill_level == '0);
  assign almost_full = (fill_level >= PW'(AFULL_LVL));
  assign pkt_active  = (pkt_remaining != '0);

  assign wr_acc   = write_enb && !full && !soft_reset;
  assign rd_acc   = read_enb && !empty && !soft_reset;
  assign rd_entry = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfd_d1 <= 1'b0;
    else       lfd_d1 <= lfd_state;
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wptr[AW-1:0]] <= {lfd_d1, data_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr          <= '0;
      rptr          <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      pkt_remaining <= '0;
    end else if (soft_reset) begin
      wptr          <= '0;
      rptr          <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      pkt_remaining <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PW'(1);
      if (rd_acc) begin
        rptr       <= rptr + PW'(1);
        data_out   <= rd_entry[WIDTH-1:0];
        data_valid <= 1'b1;
        // Header byte reloads with payload length plus the trailing parity byte.
        if (rd_entry[WIDTH])
          pkt_remaining <= RW'(rd_entry[LEN_MSB:LEN_LSB]) + RW'(1);
        else if (pkt_remaining != '0)
          pkt_remaining <= pkt_remaining - RW'(1);
      end else begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef ROUTER_PKT_FIFO_ERR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (soft_reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (write_enb && full) overflow_err  <= 1'b1;
      if (read_enb && empty) underflow_err <= 1'b1;
    end
  end
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: directed plus randomized checks of router_pkt_fifo against a queue-based reference model.
module tb_router_pkt_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
`ifdef ROUTER_PKT_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             soft_reset = 1'b0;
  logic             write_enb = 1'b0;
  logic             read_enb = 1'b0;
  logic             lfd_state = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [4:0]       fill_level;
  logic             pkt_active;
  logic [6:0]       pkt_remaining;
  logic             overflow_err;
  logic             underflow_err;

  router_pkt_fifo dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .fill_level(fill_level), .pkt_active(pkt_active), .pkt_remaining(pkt_remaining),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [8:0] q[$];
  logic [7:0] m_dout;
  bit         m_valid;
  int         m_rem;
  bit         m_ovf;
  bit         m_unf;
  bit         m_lfd;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0; m_valid = 0; m_rem = 0; m_ovf = 0; m_unf = 0; m_lfd = 0;
  endtask

  task automatic model_edge();
    logic [8:0] e;
    int n;
    n = q.size();
    if (soft_reset) begin
      q.delete();
      m_dout = '0; m_valid = 0; m_rem = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (ERR_EN && write_enb && n == DEPTH) m_ovf = 1;
      if (ERR_EN && read_enb && n == 0) m_unf = 1;
      if (read_enb && n != 0) begin
        e = q.pop_front();
        m_dout = e[7:0];
        m_valid = 1;
        if (e[8]) m_rem = int'(e[7:2]) + 1;
        else if (m_rem != 0) m_rem = m_rem - 1;
      end else begin
        m_valid = 0;
      end
      if (write_enb && n != DEPTH) q.push_back({m_lfd, data_in});
    end
    m_lfd = lfd_state;
  endtask

  task automatic check_all();
    check("data_out", 32'(data_out), 32'(m_dout));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("fill_level", 32'(fill_level), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("almost_full", 32'(almost_full), 32'(q.size() >= 12));
    check("pkt_remaining", 32'(pkt_remaining), 32'(m_rem));
    check("pkt_active", 32'(pkt_active), 32'(m_rem != 0));
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
    check("underflow_err", 32'(underflow_err), 32'(m_unf));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit w, input bit r, input bit l, input logic [7:0] d);
    write_enb = w; read_enb = r; lfd_state = l; data_in = d;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    check("reset_fill", 32'(fill_level), 32'd0);
    reset = 1'b0;

    // Header 0x0C (length 3) then 3 payload bytes and parity
    set_in(0, 0, 1, 8'h00); tick();
    set_in(1, 0, 0, 8'h0C); tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 8'($urandom)); tick();
    end
    set_in(0, 1, 0, 8'h00);
    tick();
    check("hdr_data", 32'(data_out), 32'h0C);
    check("hdr_valid", 32'(data_valid), 32'd1);
    check("hdr_rem", 32'(pkt_remaining), 32'd4);
    for (int k = 1; k < 5; k++) begin
      tick();
      check("pkt_rem_seq", 32'(pkt_remaining), 32'(4 - k));
    end
    set_in(0, 0, 0, 8'h00); tick();
    check("pkt_empty", 32'(empty), 32'd1);

    // Fill to DEPTH, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 0, 0, 8'($urandom)); tick();
      check("afull_ramp", 32'(almost_full), 32'(i + 1 >= 12));
    end
    check("full16", 32'(full), 32'd1);
    set_in(1, 0, 0, 8'hEE); tick();
    check("ovf_fill", 32'(fill_level), 32'd16);
    check("ovf_err", 32'(overflow_err), 32'(ERR_EN));
    for (int i = 0; i < DEPTH; i++) begin
      set_in(0, 1, 0, 8'h00); tick();
    end

    // Fill 8, then concurrent read/write across two wraps
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 0, 8'($urandom)); tick();
    end
    for (int i = 0; i < 40; i++) begin
      set_in(1, 1, 0, 8'($urandom)); tick();
      check("rw_fill8", 32'(fill_level), 32'd8);
    end

    // Fill to 5 (from 8 drain 3), then soft_reset with write
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 8'h00); tick();
    end
    check("pre_soft_fill", 32'(fill_level), 32'd5);
    set_in(1, 0, 0, 8'h55); soft_reset = 1'b1; tick();
    soft_reset = 1'b0;
    check("soft_fill", 32'(fill_level), 32'd0);
    check("soft_valid", 32'(data_valid), 32'd0);
    check("soft_rem", 32'(pkt_remaining), 32'd0);

    // Read on empty holds data_out
    set_in(1, 0, 0, 8'hA5); tick();
    set_in(0, 1, 0, 8'h00); tick();
    tick();
    check("empty_rd_dout", 32'(data_out), 32'hA5);
    check("empty_rd_valid", 32'(data_valid), 32'd0);
    check("unf_err", 32'(underflow_err), 32'(ERR_EN));

    // Randomized traffic with headers and occasional flush
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
             1'($urandom_range(0, 9) == 0), 8'($urandom));
      soft_reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    soft_reset = 1'b0;

    // Asynchronous reset mid-packet
    set_in(0, 0, 1, 8'h00); tick();
    set_in(1, 0, 0, 8'h14); tick();
    set_in(1, 0, 0, 8'h33); tick();
    set_in(0, 1, 0, 8'h00); tick();
    set_in(0, 0, 0, 8'h00);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("arst_rem", 32'(pkt_remaining), 32'd0);
    check("arst_valid", 32'(data_valid), 32'd0);
    #1;
    reset = 1'b0;
    set_in(1, 0, 0, 8'h77); tick();
    check("post_rst_fill", 32'(fill_level), 32'd1);
    set_in(0, 1, 0, 8'h00); tick();
    check("post_rst_data", 32'(data_out), 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised successor to the per-destination router FIFO; one instance per output port of a router.
Stores WIDTH-bit bytes plus a header-marker bit and tracks remaining packet length with a down-counter. Adds registered data_valid, fill level, programmable almost_full and packet-status outputs.
Sits between the router register/FSM (write side) and the destination read port (read side).

Parameters:
WIDTH, 8, data byte width
DEPTH, 16, entries; power of 2, minimum 4
LEN_MSB, 7, MSB of payload-length field within a header byte
LEN_LSB, 2, LSB of payload-length field within a header byte
AFULL_LVL, 12, fill_level at or above which almost_full asserts; 1..DEPTH

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
soft_reset  input  1  synchronous flush (read-port timeout)
write_enb  input  1  write request
read_enb  input  1  read request
lfd_state  input  1  FSM load-first-data state; marks the header byte
data_in  input  WIDTH  write data
data_out  output  WIDTH  registered read data
data_valid  output  1  data_out holds a byte popped in the previous cycle
full  output  1  fill_level == DEPTH
empty  output  1  fill_level == 0
almost_full  output  1  fill_level >= AFULL_LVL
fill_level  output  $clog2(DEPTH)+1  entries stored
pkt_active  output  1  pkt_remaining != 0
pkt_remaining  output  LEN_MSB-LEN_LSB+2  bytes left in the current packet (payload + parity)
overflow_err  output  1  sticky; see Optional Feature
underflow_err  output  1  sticky; see Optional Feature

Behaviour:
- Reset (async, active-high): pointers, fill_level, pkt_remaining, data_out, data_valid and err flags all 0. Memory is not cleared. The lfd delay register is cleared to 0.
- Pointers are $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit. full/empty/almost_full are combinational from fill_level.
- Entry width is WIDTH+1. The stored flag is lfd_state registered one cycle earlier (lfd_d1), which aligns it with the FSM data pipeline.
- Write is accepted when write_enb && !full: mem[wptr] <= {lfd_d1, data_in}; wptr++. A write while full is dropped and the pointer is unchanged.
- Read is accepted when read_enb && !empty: data_out <= mem[rptr] data bits; rptr++; data_valid <= 1 on the next edge (1-cycle latency). Otherwise data_valid <= 0 and data_out holds its value. No tri-state is used anywhere.
- Simultaneous accepted read and write: fill_level unchanged. A write is not accepted when full even if a read occurs in the same cycle.
- Pointers wrap modulo 2*DEPTH. Index is ptr[$clog2(DEPTH)-1:0].
- Down-counter on each accepted read:
  - If the popped entry flag is 1: pkt_remaining <= entry[LEN_MSB:LEN_LSB] + 1 (payload + parity), zero-extended.
  - Otherwise, if pkt_remaining != 0: decrement.
  - Otherwise: hold.
- soft_reset (synchronous) has priority over same-cycle read/write. It clears pointers, fill_level, pkt_remaining, data_out, data_valid and err flags. The lfd delay register is unaffected.
- reset asserted mid-operation clears state immediately. The first write is accepted on the first edge after deassertion.

Optional Feature:
- Macro: ROUTER_PKT_FIFO_ERR_EN.
- Defined: overflow_err sets on write_enb && full; underflow_err sets on read_enb && empty. Both are sticky until reset or soft_reset; a set and soft_reset in the same cycle leaves the flag clear.
- Undefined: both outputs tied 0 and no flops are inferred.

Test Plan:
- Reset, then write header 0x0C (length 3) with lfd_d1=1, then 3 payload bytes and 1 parity byte; read all 5. Required: header appears on data_out one cycle after its read with data_valid=1; pkt_remaining goes 4,3,2,1,0; empty=1 at end.
- Write 16 bytes with DEPTH=16. Required: full=1, fill_level=16, almost_full=1 from the 12th write. A 17th write is dropped and overflow_err=1 (with ERR_EN). Read 16: data matches in order.
- Hold fill at 8, assert read and write together for 40 cycles. Required: fill_level stays 8, wrap crosses twice, data order preserved.
- Fill 5 bytes, pulse soft_reset together with write_enb. Required: the write is ignored; fill_level=0, empty=1, data_valid=0, pkt_remaining=0 the next cycle.
- read_enb on empty. Required: data_valid=0, data_out unchanged, underflow_err=1 (ERR_EN) or 0 (not defined).
- Assert reset asynchronously between edges mid-packet. Required: outputs zero before the next edge; writes accepted normally after release.
